div_edge_counter: RTL and testbench

- Downstream consumer of the clock divider output. Treats `div_clk` as a data signal, never as a clock.
- Synchronises it into the system `clk` domain and detects its rising edges.
- Counts those edges under a start/stop/clear run-control FSM.
- Provides a wrap-around count, single-cycle tick/wrap strobes and a run status for LEDs/7-seg drivers on the board.

---
 rtl/div_edge_counter_if.sv | 29 ++
 rtl/div_edge_counter.sv | 129 ++++++++++++
 tb/tb_div_edge_counter.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/div_edge_counter_if.sv
// div_edge_counter_if
//   Bundles the run-control commands, the sampled divided clock and the
//   count/status outputs of div_edge_counter.
//   master : drives div_clk_in, start, stop and clear; observes count,
//            tick, wrap and running.
//   slave  : the counter side (the opposite directions).
//   WIDTH must match the WIDTH of the attached div_edge_counter.
interface div_edge_counter_if #(
   parameter int WIDTH = 4
);
   logic             div_clk_in;
   logic             start;
   logic             stop;
   logic             clear;
   logic [WIDTH-1:0] count;
   logic             tick;
   logic             wrap;
   logic             running;

   modport master (
      output div_clk_in, start, stop, clear,
      input  count, tick, wrap, running
   );

   modport slave (
      input  div_clk_in, start, stop, clear,
      output count, tick, wrap, running
   );
endinterface

// File: rtl/div_edge_counter.sv
// div_edge_counter
//   Treats the clock-divider output as data: it synchronises div_clk_in into
//   clk, detects its edges and counts them under an IDLE/RUN/PAUSE
//   run-control FSM. The count wraps to 0 after MAX_COUNT.
//
//   Ports:
//     clk          system clock, the only clock of this block
//     rst          synchronous, active-high reset
//     bus (slave)  div_clk_in - divided clock, asynchronous, sampled only
//                  start/stop/clear - one-cycle commands
//                  count   - registered edge count
//                  tick    - one-cycle pulse per counted edge
//                  wrap    - one-cycle pulse on MAX_COUNT -> 0
//                  running - high while the FSM is in RUN
//
//   Build option:
//     DIV_EDGE_BOTH_EN  when defined, both rising and falling edges of
//                       div_clk_in are counted; otherwise rising only.
//
//   A div_clk_in edge first captured by s1 at clk edge N appears on
//   count/tick/wrap at edge N+2. div_clk_in high and low phases must each
//   last at least 2 clk cycles.
module div_edge_counter #(
   parameter int WIDTH     = 4,
   parameter int MAX_COUNT = 9
) (
   input  logic               clk,
   input  logic               rst,
   div_edge_counter_if.slave  bus
);

   generate
      if (MAX_COUNT <= 0 || MAX_COUNT >= (2 ** WIDTH)) begin : g_bad_max_count
         $error("div_edge_counter: MAX_COUNT must satisfy 0 < MAX_COUNT < 2**WIDTH");
      end
   endgenerate

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_RUN   = 2'd1;
   localparam logic [1:0] ST_PAUSE = 2'd2;

   localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MAX_COUNT);
   localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);

   logic             s1_reg;
   logic             s2_reg;
   logic             prev_reg;
   logic [1:0]       state_reg;
   logic [1:0]       state_next;
   logic [WIDTH-1:0] count_reg;
   logic [WIDTH-1:0] count_next;
   logic             tick_reg;
   logic             tick_next;
   logic             wrap_reg;
   logic             wrap_next;
   logic             running_reg;
   logic             rise;

   // The edge detector runs in every state so prev_reg always tracks s2_reg;
   // entering RUN with div_clk_in already high therefore yields no edge.
`ifdef DIV_EDGE_BOTH_EN
   assign rise = s2_reg ^ prev_reg;
`else
   assign rise = s2_reg & ~prev_reg;
`endif

   // Run-control FSM: clear beats stop beats start.
   always_comb begin
      state_next = state_reg;
      if (bus.clear) begin
         state_next = ST_IDLE;
      end else begin
         case (state_reg)
            ST_IDLE:  if (bus.start) state_next = ST_RUN;
            ST_RUN:   if (bus.stop)  state_next = ST_PAUSE;
            ST_PAUSE: if (bus.start && !bus.stop) state_next = ST_RUN;
            default:  state_next = ST_IDLE;
         endcase
      end
   end

   // Counting keys off the registered state, so an edge arriving in the
   // same cycle that stop is sampled is still counted.
   always_comb begin
      count_next = count_reg;
      tick_next  = 1'b0;
      wrap_next  = 1'b0;
      if (bus.clear) begin
         count_next = '0;
      end else if (state_reg == ST_RUN && rise) begin
         tick_next = 1'b1;
         if (count_reg == MAX_VAL) begin
            count_next = '0;
            wrap_next  = 1'b1;
         end else begin
            count_next = count_reg + ONE;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         s1_reg      <= 1'b0;
         s2_reg      <= 1'b0;
         prev_reg    <= 1'b0;
         state_reg   <= ST_IDLE;
         count_reg   <= '0;
         tick_reg    <= 1'b0;
         wrap_reg    <= 1'b0;
         running_reg <= 1'b0;
      end else begin
         s1_reg      <= bus.div_clk_in;
         s2_reg      <= s1_reg;
         prev_reg    <= s2_reg;
         state_reg   <= state_next;
         count_reg   <= count_next;
         tick_reg    <= tick_next;
         wrap_reg    <= wrap_next;
         // Registered from the next state so it rises with entry into RUN.
         running_reg <= (state_next == ST_RUN);
      end
   end

   assign bus.count   = count_reg;
   assign bus.tick    = tick_reg;
   assign bus.wrap    = wrap_reg;
   assign bus.running = running_reg;

endmodule

// File: tb/tb_div_edge_counter.sv
// tb_div_edge_counter
//   Scoreboard bench for div_edge_counter. Every div_clk_in edge that the
//   bench's own run-control model says should be counted pushes the expected
//   count, wrap flag and arrival cycle; a negedge monitor pops one entry per
//   tick and flags spurious, late or missing ticks.
module tb_div_edge_counter;

   localparam int WIDTH     = 4;
   localparam int MAX_COUNT = 9;

`ifdef DIV_EDGE_BOTH_EN
   localparam bit BOTH = 1'b1;
`else
   localparam bit BOTH = 1'b0;
`endif

   localparam int M_IDLE  = 0;
   localparam int M_RUN   = 1;
   localparam int M_PAUSE = 2;

   logic clk = 1'b0;
   logic rst = 1'b1;

   div_edge_counter_if #(.WIDTH(WIDTH)) bus ();

   div_edge_counter #(
      .WIDTH     (WIDTH),
      .MAX_COUNT (MAX_COUNT)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      int cyc;
      int cnt;
      int wrap;
   } exp_t;

   exp_t sb_q[$];

   int checks   = 0;
   int failures = 0;
   int exp_cnt  = 0;
   int m_state  = M_IDLE;

   task automatic check(input string tag, input logic [31:0] observed,
                        input logic [31:0] expected);
      checks++;
      if (observed !== expected) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, observed, expected, cyc);
      end
   endtask

   // Expected result of one counted edge; it appears 3 negedges after the
   // negedge that drove the edge (capture, sync, count).
   task automatic push_edge();
      exp_t e;
      e.wrap = 0;
      if (exp_cnt == MAX_COUNT) begin
         exp_cnt = 0;
         e.wrap  = 1;
      end else begin
         exp_cnt = exp_cnt + 1;
      end
      e.cyc = cyc + 3;
      e.cnt = exp_cnt;
      sb_q.push_back(e);
      $display("edge  cyc=%0d level=%0b expect count=%0d wrap=%0d", cyc, bus.div_clk_in, e.cnt, e.wrap);
   endtask

   // Drive div_clk_in to v and hold it for 'hold' cycles.
   task automatic drive_div(input logic v, input int hold);
      logic old;
      @(negedge clk);
      old = bus.div_clk_in;
      bus.div_clk_in = v;
      if (m_state == M_RUN && old != v && (v || BOTH)) push_edge();
      repeat (hold - 1) @(negedge clk);
   endtask

   task automatic period(input int n);
      for (int i = 0; i < n; i++) begin
         drive_div(1'b1, 4);
         drive_div(1'b0, 4);
      end
   endtask

   // One-cycle command pulse; the model applies the same command priority.
   task automatic pulse(input bit s, input bit p, input bit c);
      @(negedge clk);
      bus.start = s;
      bus.stop  = p;
      bus.clear = c;
      if (c) begin
         m_state = M_IDLE;
         exp_cnt = 0;
      end else if (m_state == M_IDLE && s) begin
         m_state = M_RUN;
      end else if (m_state == M_RUN && p) begin
         m_state = M_PAUSE;
      end else if (m_state == M_PAUSE && s && !p) begin
         m_state = M_RUN;
      end
      $display("cmd   cyc=%0d start=%0b stop=%0b clear=%0b", cyc, s, p, c);
      @(negedge clk);
      bus.start = 1'b0;
      bus.stop  = 1'b0;
      bus.clear = 1'b0;
   endtask

   // Tick monitor.
   always @(negedge clk) begin
      exp_t e;
      if (!rst) begin
         if (bus.tick) begin
            if (sb_q.size() == 0) begin
               check("spurious_tick", 32'(bus.tick), 32'd0);
            end else begin
               e = sb_q.pop_front();
               $display("tick  cyc=%0d count=%0d wrap=%0b", cyc, bus.count, bus.wrap);
               check("tick_cycle", 32'(cyc), 32'(e.cyc));
               check("tick_count", 32'(bus.count), 32'(e.cnt));
               check("tick_wrap", 32'(bus.wrap), 32'(e.wrap));
            end
         end else begin
            if (bus.wrap) check("wrap_without_tick", 32'(bus.wrap), 32'd0);
            if (sb_q.size() > 0 && sb_q[0].cyc < cyc) begin
               e = sb_q.pop_front();
               check("missed_tick", 32'(bus.tick), 32'd1);
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      bus.div_clk_in = 1'b0;
      bus.start      = 1'b0;
      bus.stop       = 1'b0;
      bus.clear      = 1'b0;

      // Reset, then edges with no start.
      rst = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      check("reset_count", 32'(bus.count), 32'd0);
      check("reset_tick", 32'(bus.tick), 32'd0);
      check("reset_wrap", 32'(bus.wrap), 32'd0);
      check("reset_running", 32'(bus.running), 32'd0);
      period(5);
      check("idle_count", 32'(bus.count), 32'd0);
      check("idle_running", 32'(bus.running), 32'd0);

      // Basic counting and latency.
      pulse(1'b1, 1'b0, 1'b0);
      check("start_running", 32'(bus.running), 32'd1);
      period(3);
      check("basic_count", 32'(bus.count), 32'(exp_cnt));

      // Run on through the wrap (10 rising edges from start).
      period(7);
      check("wrap_count", 32'(bus.count), 32'(exp_cnt));

      // Pause and resume with div_clk_in already high.
      period(4);
      pulse(1'b0, 1'b1, 1'b0);
      check("pause_running", 32'(bus.running), 32'd0);
      period(3);
      check("pause_count", 32'(bus.count), 32'(exp_cnt));
      drive_div(1'b1, 4);
      pulse(1'b1, 1'b0, 1'b0);
      repeat (3) @(negedge clk);
      check("resume_running", 32'(bus.running), 32'd1);
      check("resume_no_edge", 32'(bus.count), 32'(exp_cnt));
      drive_div(1'b0, 4);
      drive_div(1'b1, 4);
      drive_div(1'b0, 4);
      check("resume_count", 32'(bus.count), 32'(exp_cnt));

      // Clear coinciding with a detected edge.
      period(2);
      check("pre_clear_count", 32'(bus.count), 32'(exp_cnt));
      @(negedge clk);
      bus.div_clk_in = 1'b1;
      @(negedge clk);
      pulse(1'b0, 1'b0, 1'b1);
      repeat (2) @(negedge clk);
      check("clear_count", 32'(bus.count), 32'd0);
      check("clear_running", 32'(bus.running), 32'd0);
      drive_div(1'b0, 4);

      // start+stop together while paused.
      pulse(1'b1, 1'b0, 1'b0);
      pulse(1'b0, 1'b1, 1'b0);
      pulse(1'b1, 1'b1, 1'b0);
      check("start_stop_running", 32'(bus.running), 32'd0);
      period(1);
      check("start_stop_count", 32'(bus.count), 32'd0);

      // Synchronous reset in the middle of a run.
      pulse(1'b1, 1'b0, 1'b0);
      period(6);
      check("pre_reset_count", 32'(bus.count), 32'(exp_cnt));
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      m_state = M_IDLE;
      exp_cnt = 0;
      period(1);
      check("post_reset_count", 32'(bus.count), 32'd0);
      check("post_reset_running", 32'(bus.running), 32'd0);
      pulse(1'b1, 1'b0, 1'b0);
      period(1);
      check("restart_count", 32'(bus.count), 32'(exp_cnt));

      repeat (6) @(negedge clk);
      check("scoreboard_drained", 32'(sb_q.size()), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
